// File: rtl/rs_param_pkg.sv
// Shared defaults and helper types for the parametrised reservation station.
// Consumers: rs_param, rs_param_select (age ordering enabled by RS_AGE_ORDER_EN).
package rs_param_pkg;

  localparam int unsigned RS_SIZE_DEF = 16;
  localparam int unsigned ROB_W_DEF   = 4;
  localparam int unsigned N_WB_DEF    = 2;
  localparam int unsigned OP_W_DEF    = 11;
  localparam int unsigned XLEN        = 32;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    SRC_DC   = 2'd0,
    SRC_WB   = 2'd1,
    SRC_WAIT = 2'd2
  } opnd_src_e;

endpackage

// File: rtl/rs_param_select.sv
// Ready-entry picker: oldest-ready via age matrix when RS_AGE_ORDER_EN is defined,
// otherwise lowest-index ready. Purely combinational.
module rs_param_select
  import rs_param_pkg::*;
#(
  parameter int unsigned N     = RS_SIZE_DEF,
  parameter int unsigned IDX_W = $clog2(RS_SIZE_DEF)
) (
  input  logic [N-1:0]     ready_i,
`ifdef RS_AGE_ORDER_EN
  input  logic [N*N-1:0]   older_i,
`endif
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

`ifdef RS_AGE_ORDER_EN
  logic blocked;

  // older_i[j*N+i] set means entry j is older than entry i
  always_comb begin
    grant_o = '0;
    blocked = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      blocked = 1'b0;
      for (int unsigned j = 0; j < N; j++) begin
        if (ready_i[j] && older_i[j*N+i]) blocked = 1'b1;
      end
      grant_o[i] = ready_i[i] && !blocked;
    end
  end
`else
  logic found;

  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (ready_i[i] && !found) begin
        grant_o[i] = 1'b1;
        found      = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    idx_o = '0;
    any_o = |ready_i;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant_o[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/rs_param.sv
// Parametrised reservation station: entry array, wakeup snooping and registered issue slot.
// Define RS_AGE_ORDER_EN to issue the oldest ready entry instead of the lowest-index one.
module rs_param
  import rs_param_pkg::*;
#(
  parameter int unsigned RS_SIZE = RS_SIZE_DEF,
  parameter int unsigned ROB_W   = ROB_W_DEF,
  parameter int unsigned N_WB    = N_WB_DEF,
  parameter int unsigned OP_W    = OP_W_DEF
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      rob_clear,
  input  logic                      dc_valid,
  input  logic [31:0]               dc_pc,
  input  logic [OP_W-1:0]           dc_op,
  input  logic [31:0]               dc_imm,
  input  logic                      dc_iQi,
  input  logic                      dc_iQj,
  input  logic [ROB_W-1:0]          dc_Qi,
  input  logic [ROB_W-1:0]          dc_Qj,
  input  logic [31:0]               dc_Vi,
  input  logic [31:0]               dc_Vj,
  input  logic [ROB_W-1:0]          dc_Qdest,
  output logic                      rs_full,
  output logic [$clog2(RS_SIZE):0]  rs_free_cnt,
  input  logic [N_WB-1:0]           wb_valid,
  input  logic [N_WB*ROB_W-1:0]     wb_rob_id,
  input  logic [N_WB*32-1:0]        wb_value,
  output logic                      iss_valid,
  input  logic                      iss_ready,
  output logic [OP_W-1:0]           iss_op,
  output logic [31:0]               iss_pc,
  output logic [31:0]               iss_imm,
  output logic [31:0]               iss_v1,
  output logic [31:0]               iss_v2,
  output logic [ROB_W-1:0]          iss_rob_id
);

  localparam int unsigned IDX_W = $clog2(RS_SIZE);
  localparam int unsigned CNT_W = IDX_W + 1;

  logic [RS_SIZE-1:0] busy_q, busy_d, iqi_q, iqi_d, iqj_q, iqj_d;
  logic [ROB_W-1:0]   qi_q [RS_SIZE], qi_d [RS_SIZE];
  logic [ROB_W-1:0]   qj_q [RS_SIZE], qj_d [RS_SIZE];
  logic [ROB_W-1:0]   dest_q [RS_SIZE], dest_d [RS_SIZE];
  logic [31:0]        vi_q [RS_SIZE], vi_d [RS_SIZE];
  logic [31:0]        vj_q [RS_SIZE], vj_d [RS_SIZE];
  logic [31:0]        pc_q [RS_SIZE], pc_d [RS_SIZE];
  logic [31:0]        imm_q [RS_SIZE], imm_d [RS_SIZE];
  logic [OP_W-1:0]    op_q [RS_SIZE], op_d [RS_SIZE];

  logic               iss_valid_q, iss_valid_d;
  logic [OP_W-1:0]    iss_op_q, iss_op_d;
  logic [31:0]        iss_pc_q, iss_pc_d, iss_imm_q, iss_imm_d;
  logic [31:0]        iss_v1_q, iss_v1_d, iss_v2_q, iss_v2_d;
  logic [ROB_W-1:0]   iss_rob_q, iss_rob_d;

  logic [RS_SIZE-1:0] ready, grant;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic               any_ready, free_hit, dc_fire;
  logic [CNT_W-1:0]   free_cnt;
  logic [32:0]        wk_i, wk_j, lk_i, lk_j;
  opnd_src_e          src_i, src_j;

  // {hit, value} of the lowest-index valid channel broadcasting tag
  function automatic logic [32:0] wb_lookup(input logic [ROB_W-1:0] tag);
    logic [32:0] r;
    r = '0;
    for (int unsigned k = 0; k < N_WB; k++) begin
      if (!r[32] && wb_valid[k] && wb_rob_id[k*ROB_W +: ROB_W] == tag)
        r = {1'b1, wb_value[k*32 +: 32]};
    end
    return r;
  endfunction

  assign ready   = busy_q & iqi_q & iqj_q;
  assign rs_full = &busy_q;
  assign dc_fire = dc_valid && !rs_full;

  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    free_cnt = '0;
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      free_cnt = free_cnt + CNT_W'(!busy_q[i]);
      if (!busy_q[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
  end

  assign rs_free_cnt = free_cnt;

`ifdef RS_AGE_ORDER_EN
  logic [RS_SIZE*RS_SIZE-1:0] older_q, older_d;

  // New entry is younger than every currently busy one; freed entries drop out of the order
  always_comb begin
    older_d = older_q;
    if (dc_fire) begin
      for (int unsigned j = 0; j < RS_SIZE; j++) begin
        older_d[int'(free_idx)*RS_SIZE + j] = 1'b0;
        older_d[j*RS_SIZE + int'(free_idx)] = busy_q[j];
      end
    end
    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      for (int unsigned j = 0; j < RS_SIZE; j++) begin
        older_d[i*RS_SIZE + j] = older_d[i*RS_SIZE + j] & busy_d[i] & busy_d[j];
      end
    end
  end

  rs_param_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_select (
    .ready_i (ready),
    .older_i (older_q),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (any_ready)
  );
`else
  rs_param_select #(.N(RS_SIZE), .IDX_W(IDX_W)) u_select (
    .ready_i (ready),
    .grant_o (grant),
    .idx_o   (sel_idx),
    .any_o   (any_ready)
  );
`endif

  always_comb begin
    busy_d = busy_q;  iqi_d = iqi_q;  iqj_d = iqj_q;
    qi_d   = qi_q;    qj_d  = qj_q;   dest_d = dest_q;
    vi_d   = vi_q;    vj_d  = vj_q;
    pc_d   = pc_q;    imm_d = imm_q;  op_d = op_q;
    iss_valid_d = iss_valid_q;
    iss_op_d  = iss_op_q;  iss_pc_d = iss_pc_q;  iss_imm_d = iss_imm_q;
    iss_v1_d  = iss_v1_q;  iss_v2_d = iss_v2_q;  iss_rob_d = iss_rob_q;
    wk_i = '0;  wk_j = '0;  lk_i = '0;  lk_j = '0;
    src_i = SRC_WAIT;  src_j = SRC_WAIT;

    for (int unsigned i = 0; i < RS_SIZE; i++) begin
      if (busy_q[i] && !iqi_q[i]) begin
        wk_i = wb_lookup(qi_q[i]);
        if (wk_i[32]) begin
          iqi_d[i] = 1'b1;
          vi_d[i]  = wk_i[31:0];
        end
      end
      if (busy_q[i] && !iqj_q[i]) begin
        wk_j = wb_lookup(qj_q[i]);
        if (wk_j[32]) begin
          iqj_d[i] = 1'b1;
          vj_d[i]  = wk_j[31:0];
        end
      end
    end

    if (!iss_valid_q || iss_ready) begin
      if (any_ready) begin
        iss_valid_d = 1'b1;
        iss_op_d    = op_q[sel_idx];
        iss_pc_d    = pc_q[sel_idx];
        iss_imm_d   = imm_q[sel_idx];
        iss_v1_d    = vi_q[sel_idx];
        iss_v2_d    = vj_q[sel_idx];
        iss_rob_d   = dest_q[sel_idx];
        busy_d      = busy_d & ~grant;
      end else begin
        iss_valid_d = 1'b0;
      end
    end

    // Dispatch targets a registered-free entry, so it never collides with the issued one
    if (dc_fire) begin
      lk_i  = wb_lookup(dc_Qi);
      lk_j  = wb_lookup(dc_Qj);
      src_i = dc_iQi ? SRC_DC : (lk_i[32] ? SRC_WB : SRC_WAIT);
      src_j = dc_iQj ? SRC_DC : (lk_j[32] ? SRC_WB : SRC_WAIT);
      busy_d[free_idx] = 1'b1;
      op_d[free_idx]   = dc_op;
      pc_d[free_idx]   = dc_pc;
      imm_d[free_idx]  = dc_imm;
      dest_d[free_idx] = dc_Qdest;
      qi_d[free_idx]   = dc_Qi;
      qj_d[free_idx]   = dc_Qj;
      case (src_i)
        SRC_DC:  begin iqi_d[free_idx] = 1'b1; vi_d[free_idx] = dc_Vi;       end
        SRC_WB:  begin iqi_d[free_idx] = 1'b1; vi_d[free_idx] = lk_i[31:0];  end
        default: iqi_d[free_idx] = 1'b0;
      endcase
      case (src_j)
        SRC_DC:  begin iqj_d[free_idx] = 1'b1; vj_d[free_idx] = dc_Vj;       end
        SRC_WB:  begin iqj_d[free_idx] = 1'b1; vj_d[free_idx] = lk_j[31:0];  end
        default: iqj_d[free_idx] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q      <= '0;
      iss_valid_q <= 1'b0;
`ifdef RS_AGE_ORDER_EN
      older_q     <= '0;
`endif
    end else if (rdy_in) begin
      if (rob_clear) begin
        busy_q      <= '0;
        iss_valid_q <= 1'b0;
`ifdef RS_AGE_ORDER_EN
        older_q     <= '0;
`endif
      end else begin
        busy_q      <= busy_d;
        iss_valid_q <= iss_valid_d;
`ifdef RS_AGE_ORDER_EN
        older_q     <= older_d;
`endif
      end
    end
  end

  // Payload needs no reset: it is only observed through busy/iss_valid
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      iqi_q <= iqi_d;  iqj_q <= iqj_d;
      qi_q  <= qi_d;   qj_q  <= qj_d;   dest_q <= dest_d;
      vi_q  <= vi_d;   vj_q  <= vj_d;
      pc_q  <= pc_d;   imm_q <= imm_d;  op_q <= op_d;
      iss_op_q  <= iss_op_d;   iss_pc_q <= iss_pc_d;  iss_imm_q <= iss_imm_d;
      iss_v1_q  <= iss_v1_d;   iss_v2_q <= iss_v2_d;  iss_rob_q <= iss_rob_d;
    end
  end

  assign iss_valid  = iss_valid_q;
  assign iss_op     = iss_op_q;
  assign iss_pc     = iss_pc_q;
  assign iss_imm    = iss_imm_q;
  assign iss_v1     = iss_v1_q;
  assign iss_v2     = iss_v2_q;
  assign iss_rob_id = iss_rob_q;

  a_no_dispatch_when_full: assert property (@(posedge clk_in) disable iff (rst_in)
    (rdy_in && !rob_clear && dc_valid) |-> !rs_full);

endmodule

// File: tb/tb_rs_param.sv
// Scoreboard bench for rs_param: directed dispatch/wakeup/issue scenarios, queue-based issue checking.
module tb_rs_param;
  import rs_param_pkg::*;

  typedef struct packed {
    logic [10:0] op;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [3:0]  rob;
  } iss_t;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, rob_clear, dc_valid;
  logic [31:0] dc_pc, dc_imm, dc_Vi, dc_Vj;
  logic [10:0] dc_op;
  logic        dc_iQi, dc_iQj;
  logic [3:0]  dc_Qi, dc_Qj, dc_Qdest;
  logic        rs_full;
  logic [4:0]  rs_free_cnt;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_rob_id;
  logic [63:0] wb_value;
  logic        iss_valid, iss_ready;
  logic [10:0] iss_op;
  logic [31:0] iss_pc, iss_imm, iss_v1, iss_v2;
  logic [3:0]  iss_rob_id;

  iss_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [10:0] OP_A = {1'b0, 3'b000, OPC_OP_IMM};
  localparam logic [10:0] OP_B = {1'b1, 3'b000, OPC_OP};
  localparam logic [10:0] OP_C = {1'b0, 3'b001, OPC_BRANCH};

  always #5 clk_in = ~clk_in;

  rs_param #(.RS_SIZE(16), .ROB_W(4), .N_WB(2), .OP_W(11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .rob_clear(rob_clear),
    .dc_valid(dc_valid), .dc_pc(dc_pc), .dc_op(dc_op), .dc_imm(dc_imm),
    .dc_iQi(dc_iQi), .dc_iQj(dc_iQj), .dc_Qi(dc_Qi), .dc_Qj(dc_Qj),
    .dc_Vi(dc_Vi), .dc_Vj(dc_Vj), .dc_Qdest(dc_Qdest),
    .rs_full(rs_full), .rs_free_cnt(rs_free_cnt),
    .wb_valid(wb_valid), .wb_rob_id(wb_rob_id), .wb_value(wb_value),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_pc(iss_pc),
    .iss_imm(iss_imm), .iss_v1(iss_v1), .iss_v2(iss_v2), .iss_rob_id(iss_rob_id)
  );

  // Two channels never broadcast the same tag in one cycle
  always @(posedge clk_in) begin
    if (wb_valid == 2'b11)
      assert (wb_rob_id[3:0] != wb_rob_id[7:4]) else $error("duplicate wb tag %0d", wb_rob_id[3:0]);
  end

  // Monitor: every accepted issue is matched against the head of the expected queue
  always @(negedge clk_in) begin
    iss_t act, e;
    if (!rst_in && rdy_in && !rob_clear && iss_valid && iss_ready) begin
      act = {iss_op, iss_pc, iss_imm, iss_v1, iss_v2, iss_rob_id};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL issue_unexpected actual pc=%h rob=%0d required=no issue", iss_pc, iss_rob_id);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          failures++;
          $display("FAIL issue_fields actual op=%h pc=%h imm=%h v1=%h v2=%h rob=%0d required op=%h pc=%h imm=%h v1=%h v2=%h rob=%0d",
                   act.op, act.pc, act.imm, act.v1, act.v2, act.rob, e.op, e.pc, e.imm, e.v1, e.v2, e.rob);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic dispatch(input logic [31:0] pc, input logic [10:0] op,
                          input logic iqi, input logic [3:0] qi, input logic [31:0] vi,
                          input logic iqj, input logic [3:0] qj, input logic [31:0] vj,
                          input logic [3:0] dest);
    dc_pc = pc;  dc_op = op;  dc_imm = pc ^ 32'h0000_ffff;
    dc_iQi = iqi;  dc_Qi = qi;  dc_Vi = vi;
    dc_iQj = iqj;  dc_Qj = qj;  dc_Vj = vj;
    dc_Qdest = dest;
    dc_valid = 1'b1;
    tick();
    dc_valid = 1'b0;
  endtask

  task automatic expect_issue(input logic [31:0] pc, input logic [10:0] op,
                              input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] rob);
    iss_t e;
    e = {op, pc, pc ^ 32'h0000_ffff, v1, v2, rob};
    exp_q.push_back(e);
  endtask

  task automatic set_wb(input int ch, input logic [3:0] tag, input logic [31:0] val);
    wb_valid[ch] = 1'b1;
    wb_rob_id[ch*4 +: 4] = tag;
    wb_value[ch*32 +: 32] = val;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
    check(name, 64'(exp_q.size()), 64'd0);
    tick();
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b1;  rdy_in = 1'b1;  rob_clear = 1'b0;  dc_valid = 1'b0;
    dc_pc = '0;  dc_op = '0;  dc_imm = '0;  dc_iQi = 1'b0;  dc_iQj = 1'b0;
    dc_Qi = '0;  dc_Qj = '0;  dc_Vi = '0;  dc_Vj = '0;  dc_Qdest = '0;
    wb_valid = '0;  wb_rob_id = '0;  wb_value = '0;  iss_ready = 1'b0;

    // Reset
    tick();
    tick();
    rst_in = 1'b0;
    check("rst_full", 64'(rs_full), 64'd0);
    check("rst_free_cnt", 64'(rs_free_cnt), 64'd16);
    check("rst_iss_valid", 64'(iss_valid), 64'd0);

    // Both operands ready: issue slot valid the cycle after the write edge
    iss_ready = 1'b1;
    expect_issue(32'h100, OP_A, 32'd5, 32'd7, 4'd3);
    dispatch(32'h100, OP_A, 1'b1, 4'd0, 32'd5, 1'b1, 4'd0, 32'd7, 4'd3);
    check("t2_free_after_write", 64'(rs_free_cnt), 64'd15);
    tick();
    check("t2_iss_valid_latency", 64'(iss_valid), 64'd1);
    check("t2_free_after_issue", 64'(rs_free_cnt), 64'd16);
    drain("t2_drain");

    // Wakeup on ch1, plus same-cycle dispatch capturing the broadcast directly
    dispatch(32'h200, OP_B, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'd9, 4'd4);
    tick();
    tick();
    check("t3_waiting_no_issue", 64'(iss_valid), 64'd0);
    expect_issue(32'h200, OP_B, 32'h1234, 32'd9, 4'd4);
    expect_issue(32'h204, OP_B, 32'h1234, 32'hA, 4'd5);
    set_wb(1, 4'd6, 32'h1234);
    dispatch(32'h204, OP_B, 1'b0, 4'd6, 32'd0, 1'b1, 4'd0, 32'hA, 4'd5);
    wb_valid = '0;
    drain("t3_drain");

    // Fill all entries with unready ops, then wake exactly one
    for (int i = 0; i < 16; i++)
      dispatch(32'h300 + 32'(4*i), OP_C, 1'b0, 4'(i), 32'd0, 1'b1, 4'd0, 32'(100+i), 4'(i));
    check("t4_full", 64'(rs_full), 64'd1);
    check("t4_free_zero", 64'(rs_free_cnt), 64'd0);
    expect_issue(32'h324, OP_C, 32'h99, 32'd109, 4'd9);
    set_wb(0, 4'd9, 32'h99);
    tick();
    wb_valid = '0;
    check("t4_full_at_wake", 64'(rs_full), 64'd1);
    tick();
    check("t4_full_after_issue", 64'(rs_full), 64'd0);
    check("t4_free_one", 64'(rs_free_cnt), 64'd1);
    check("t4_iss_valid", 64'(iss_valid), 64'd1);
    drain("t4_drain");
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    check("t4_flush_free", 64'(rs_free_cnt), 64'd16);
    check("t4_flush_full", 64'(rs_full), 64'd0);

    // Hold slot with iss_ready low, then three back-to-back issues
    iss_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      dispatch(32'h400 + 32'(4*i), OP_A, 1'b0, 4'd2, 32'd0, 1'b1, 4'd0, 32'(i+1), 4'(8+i));
      expect_issue(32'h400 + 32'(4*i), OP_A, 32'h22, 32'(i+1), 4'(8+i));
    end
    set_wb(0, 4'd2, 32'h22);
    tick();
    wb_valid = '0;
    tick();
    for (int c = 0; c < 5; c++) begin
      check("t5_hold_valid", 64'(iss_valid), 64'd1);
      check("t5_hold_rob", 64'(iss_rob_id), 64'd8);
      check("t5_hold_pc", 64'(iss_pc), 64'h400);
      check("t5_hold_free", 64'(rs_free_cnt), 64'd14);
      tick();
    end
    iss_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("t5_b2b_valid", 64'(iss_valid), 64'd1);
      check("t5_b2b_rob", 64'(iss_rob_id), 64'(8+k));
      tick();
    end
    check("t5_slot_empty", 64'(iss_valid), 64'd0);
    drain("t5_drain");

    // Age order: A in entry 5, B later in entry 0, both woken together
    for (int i = 0; i < 5; i++)
      dispatch(32'h500 + 32'(4*i), OP_B, 1'b0, 4'(i), 32'd0, 1'b1, 4'd0, 32'(200+i), 4'(i));
    dispatch(32'h600, OP_C, 1'b0, 4'd12, 32'd0, 1'b1, 4'd0, 32'h61, 4'd12);
    expect_issue(32'h500, OP_B, 32'h50, 32'd200, 4'd0);
    set_wb(0, 4'd0, 32'h50);
    tick();
    wb_valid = '0;
    tick();
    dispatch(32'h700, OP_A, 1'b0, 4'd13, 32'd0, 1'b1, 4'd0, 32'h71, 4'd13);
`ifdef RS_AGE_ORDER_EN
    expect_issue(32'h600, OP_C, 32'hAA, 32'h61, 4'd12);
    expect_issue(32'h700, OP_A, 32'hBB, 32'h71, 4'd13);
`else
    expect_issue(32'h700, OP_A, 32'hBB, 32'h71, 4'd13);
    expect_issue(32'h600, OP_C, 32'hAA, 32'h61, 4'd12);
`endif
    set_wb(0, 4'd12, 32'hAA);
    set_wb(1, 4'd13, 32'hBB);
    tick();
    wb_valid = '0;
    drain("t6_drain");

    // Flush with an op in the slot and fillers still waiting
    iss_ready = 1'b0;
    set_wb(0, 4'd1, 32'h51);
    tick();
    wb_valid = '0;
    tick();
    check("t6_slot_before_flush", 64'(iss_valid), 64'd1);
    rob_clear = 1'b1;
    tick();
    rob_clear = 1'b0;
    check("t6_flush_iss_valid", 64'(iss_valid), 64'd0);
    check("t6_flush_free", 64'(rs_free_cnt), 64'd16);
    iss_ready = 1'b1;
    tick();
    tick();
    check("t6_no_issue_after_flush", 64'(iss_valid), 64'd0);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
